// File: rtl/pilha_parametrizada.sv
// Parametrised LIFO stack: push/pop strobes, UC/ULA source select, replace-top,
// synchronous flush and sticky overflow/underflow flags.
module pilha_parametrizada #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         sel_src,
  input  logic [WIDTH-1:0]             din_UC,
  input  logic [WIDTH-1:0]             din_ULA,
  input  logic                         flush,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_valid,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   tos,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] src;
  logic [PW-1:0]    tos_m1;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             replace;
  logic             wr_en;

  assign src     = sel_src ? din_ULA : din_UC;
  assign full    = (tos == DEPTH_P);
  assign empty   = (tos == '0);
  assign tos_m1  = tos - 1'b1;
  assign top_idx = tos_m1[AW-1:0];
  assign top     = empty ? '0 : mem[top_idx];

  // Push+pop on a non-empty stack overwrites the current top instead of growing.
  assign replace = push && pop && !empty;
  assign wr_en   = !flush && push && (replace || !full);
  assign wr_idx  = replace ? top_idx : tos[AW-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= src;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tos        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      tos        <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (replace) begin
        dout       <= mem[top_idx];
        dout_valid <= 1'b1;
      end else if (push) begin
        // Also covers push+pop on an empty stack, which must not flag underflow.
        if (full) begin
          overflow <= 1'b1;
        end else begin
          tos <= tos + 1'b1;
        end
      end else if (pop) begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          dout       <= mem[top_idx];
          dout_valid <= 1'b1;
          tos        <= tos_m1;
        end
      end
    end
  end

endmodule
